// File: rtl/mem_pkg.sv
// mem_pkg: types shared by the store unit and the load-side sign-extend path.
//   size_e  : access-size encoding carried on the 2-bit size port
//   state_e : store-unit FSM states
//   is_misaligned() : alignment check for a size/byte-offset pair
package mem_pkg;

   typedef enum logic [1:0] {
      SizeByte = 2'b00,
      SizeHalf = 2'b01,
      SizeWord = 2'b10,
      SizeRsvd = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StMerge,
      StWrite,
      StErr
   } state_e;

   // The reserved size is always reported as misaligned, so it never reaches memory.
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] offset);
      logic bad;
      case (sz)
         SizeByte: bad = 1'b0;
         SizeHalf: bad = offset[0];
         SizeWord: bad = (offset != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: combinational lane replacement for narrow stores (little-endian).
//   old_word : word read back from memory
//   data     : register value; low byte or low half is inserted
//   size     : access size
//   offset   : byte offset within the word (addr[1:0])
//   merged   : old_word with the addressed lane(s) replaced
module store_merge
   import mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  size_e       size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SizeByte: merged[{offset, 3'b000} +: 8]     = data[7:0];
         SizeHalf: merged[{offset[1], 4'b0000} +: 16] = data[15:0];
         default:  merged = data;
      endcase
   end

endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: store unit performing read-modify-write for byte/half stores and
// direct writes for word stores, flagging misaligned requests.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   addr, wdata, size     : store request, registered on acceptance
//   mem_addr              : word-aligned memory address
//   mem_rd/mem_wr         : memory strobes; mem_rdata valid the cycle after mem_rd
//   mem_wdata             : full word written
//   done/misaligned       : single-cycle completion and error pulses
// Only DATA_W = 32 is supported.
module mem_store_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              done,
   output logic              misaligned
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   // Holds wdata from acceptance until MERGE, then the merged word for WRITE.
   logic [DATA_W-1:0] word_q, word_d;
   size_e             size_q, size_d;
   logic [DATA_W-1:0] merged;

   store_merge u_store_merge (
      .old_word (mem_rdata),
      .data     (word_q),
      .size     (size_q),
      .offset   (addr_q[1:0]),
      .merged   (merged)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      size_d     = size_q;
      req_ready  = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      done       = 1'b0;
      misaligned = 1'b0;
      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d = addr;
               word_d = wdata;
               size_d = size_e'(size);
               if (is_misaligned(size_e'(size), addr[1:0])) begin
                  state_d = StErr;
               end else if (size_e'(size) == SizeWord) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            mem_rd  = 1'b1;
            state_d = StMerge;
         end
         StMerge: begin
            word_d  = merged;
            state_d = StWrite;
         end
         StWrite: begin
            mem_wr  = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         StErr: begin
            done       = 1'b1;
            misaligned = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = word_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         word_q  <= '0;
         size_q  <= SizeByte;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         size_q  <= size_d;
      end
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed self-checking bench for mem_store_unit. Expected
// write words are queued when a request is driven and popped at the mem_wr cycle.
module tb_mem_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  size = 2'b00;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        done;
   logic        misaligned;

   logic [31:0] mem_word = '0;
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   mem_store_unit #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .addr       (addr),
      .wdata      (wdata),
      .size       (size),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .done       (done),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   // Memory returns the word one cycle after mem_rd; junk otherwise.
   always @(posedge clk) mem_rdata <= mem_rd ? mem_word : 32'h5A5A_5A5A;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_write(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s: observed write %h expected no write", tag, mem_wdata);
      end else begin
         e = exp_q.pop_front();
         check32({tag, ".wdata"}, mem_wdata, e);
      end
   endtask

   // kind: 0 narrow (read-modify-write), 1 word, 2 misaligned
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [31:0] mem_init,
                         input logic [31:0] exp_word, input int kind);
      mem_word = mem_init;
      if (kind != 2) exp_q.push_back(exp_word);
      req_valid = 1'b1;
      addr      = a;
      wdata     = d;
      size      = sz;
      check1({tag, ".ready"}, req_ready, 1'b1);
      tick();
      // Scramble inputs; the operation in flight must not see them.
      req_valid = 1'b0;
      addr      = $urandom;
      wdata     = $urandom;
      size      = 2'($urandom);
      if (kind == 2) begin
         check1({tag, ".done"}, done, 1'b1);
         check1({tag, ".misaligned"}, misaligned, 1'b1);
         check1({tag, ".rd"}, mem_rd, 1'b0);
         check1({tag, ".wr"}, mem_wr, 1'b0);
         check1({tag, ".busy"}, req_ready, 1'b0);
      end else if (kind == 1) begin
         check1({tag, ".wr"}, mem_wr, 1'b1);
         check1({tag, ".done"}, done, 1'b1);
         check1({tag, ".rd"}, mem_rd, 1'b0);
         check1({tag, ".misaligned"}, misaligned, 1'b0);
         check32({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
         check_write(tag);
      end else begin
         check1({tag, ".rd"}, mem_rd, 1'b1);
         check1({tag, ".wr1"}, mem_wr, 1'b0);
         check1({tag, ".done1"}, done, 1'b0);
         check32({tag, ".rdaddr"}, mem_addr, {a[31:2], 2'b00});
         tick();
         check1({tag, ".rd2"}, mem_rd, 1'b0);
         check1({tag, ".wr2"}, mem_wr, 1'b0);
         check1({tag, ".done2"}, done, 1'b0);
         check1({tag, ".busy2"}, req_ready, 1'b0);
         tick();
         check1({tag, ".wr"}, mem_wr, 1'b1);
         check1({tag, ".done"}, done, 1'b1);
         check1({tag, ".rd3"}, mem_rd, 1'b0);
         check1({tag, ".misaligned"}, misaligned, 1'b0);
         check32({tag, ".wraddr"}, mem_addr, {a[31:2], 2'b00});
         check_write(tag);
      end
      tick();
      check1({tag, ".idle"}, req_ready, 1'b1);
      check1({tag, ".done_end"}, done, 1'b0);
      check1({tag, ".wr_end"}, mem_wr, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with a simultaneous word request: reset must win.
      reset     = 1'b1;
      req_valid = 1'b1;
      addr      = 32'h0000_0100;
      wdata     = 32'hFFFF_FFFF;
      size      = 2'b10;
      tick();
      tick();
      check1("rst.ready", req_ready, 1'b1);
      check1("rst.rd", mem_rd, 1'b0);
      check1("rst.wr", mem_wr, 1'b0);
      check1("rst.done", done, 1'b0);
      check1("rst.misaligned", misaligned, 1'b0);
      check32("rst.addr", mem_addr, 32'h0);
      check32("rst.wdata", mem_wdata, 32'h0);
      req_valid = 1'b0;
      reset     = 1'b0;
      tick();
      check1("rst.after_ready", req_ready, 1'b1);
      check1("rst.after_wr", mem_wr, 1'b0);

      // Narrow stores across lanes.
      run_op("byte2", 32'h0000_1002, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'h11AB_3344, 0);
      run_op("byte0", 32'h0000_1000, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 32'h1122_33AB, 0);
      run_op("byte3", 32'h0000_1003, 32'h0000_00AB, 2'b00, 32'h1122_3344, 32'hAB22_3344, 0);
      run_op("half0", 32'h0000_2000, 32'h1234_ABCD, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_ABCD, 0);
      run_op("half2", 32'h0000_2002, 32'h1234_ABCD, 2'b01, 32'hFFFF_FFFF, 32'hABCD_FFFF, 0);

      // Word store.
      run_op("word", 32'h0000_3004, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 32'hDEAD_BEEF, 1);

      // Misaligned cases.
      run_op("mis_half", 32'h0000_4001, 32'h1234_5678, 2'b01, 32'h0, 32'h0, 2);
      run_op("mis_rsvd", 32'h0000_4000, 32'h1234_5678, 2'b11, 32'h0, 32'h0, 2);
      run_op("mis_word", 32'h0000_5002, 32'h1234_5678, 2'b10, 32'h0, 32'h0, 2);

      // Reset during MERGE aborts the byte store.
      mem_word  = 32'h1122_3344;
      req_valid = 1'b1;
      addr      = 32'h0000_7001;
      wdata     = 32'h0000_0099;
      size      = 2'b00;
      tick();
      req_valid = 1'b0;
      check1("abort.rd", mem_rd, 1'b1);
      tick();
      check1("abort.in_merge", req_ready, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check1("abort.wr", mem_wr, 1'b0);
      check1("abort.done", done, 1'b0);
      check1("abort.ready", req_ready, 1'b1);
      check1("abort.rd2", mem_rd, 1'b0);
      run_op("post_abort", 32'h0000_7000, 32'hCAFE_F00D, 2'b10, 32'h0, 32'hCAFE_F00D, 1);

      // Two byte stores held back-to-back on req_valid.
      mem_word  = 32'h1122_3344;
      req_valid = 1'b1;
      addr      = 32'h0000_6001;
      wdata     = 32'h0000_0077;
      size      = 2'b00;
      exp_q.push_back(32'h1122_7744);
      check1("b2b.a_ready", req_ready, 1'b1);
      tick();
      addr  = 32'h0000_6003;
      wdata = 32'hFFFF_FF88;
      check1("b2b.a_rd", mem_rd, 1'b1);
      check1("b2b.busy1", req_ready, 1'b0);
      tick();
      check1("b2b.busy2", req_ready, 1'b0);
      tick();
      check1("b2b.busy3", req_ready, 1'b0);
      check1("b2b.a_wr", mem_wr, 1'b1);
      check1("b2b.a_done", done, 1'b1);
      check_write("b2b.a");
      exp_q.push_back(32'h8822_3344);
      tick();
      check1("b2b.b_ready", req_ready, 1'b1);
      check1("b2b.gap_wr", mem_wr, 1'b0);
      tick();
      req_valid = 1'b0;
      check1("b2b.b_rd", mem_rd, 1'b1);
      check1("b2b.b_busy", req_ready, 1'b0);
      check32("b2b.b_addr", mem_addr, 32'h0000_6000);
      tick();
      tick();
      check1("b2b.b_wr", mem_wr, 1'b1);
      check1("b2b.b_done", done, 1'b1);
      check_write("b2b.b");
      tick();
      check1("b2b.end_ready", req_ready, 1'b1);

      check32("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
